// File: rtl/branch_sequencer.sv
// Multi-cycle LEGv8 branch sequencer (B, BL, CBZ, CBNZ, B.cond, BR).
// Latches one branch, walks IDLE/LINK/TEST/JUMP and drives the 33-bit control word plus K.
module branch_sequencer #(
  parameter int DATA_W   = 64,
  parameter int LINK_REG = 30,
  parameter int ZERO_REG = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       I,
  input  logic              instr_valid,
  input  logic [4:0]        status,
  input  logic              alu_zero,
  output logic [32:0]       cw,
  output logic [DATA_W-1:0] K,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINK = 2'd1,
    TEST = 2'd2,
    JUMP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_B     = 3'd1,
    KIND_BL    = 3'd2,
    KIND_CBZ   = 3'd3,
    KIND_CBNZ  = 3'd4,
    KIND_BCOND = 3'd5,
    KIND_BR    = 3'd6
  } kind_t;

  localparam logic [4:0] LINK_A = 5'(LINK_REG);
  localparam logic [4:0] ZERO_A = 5'(ZERO_REG);

  function automatic kind_t decode_kind(input logic [31:0] ins);
    kind_t k;
    if (ins[31:26] == 6'b000101)            k = KIND_B;
    else if (ins[31:26] == 6'b100101)       k = KIND_BL;
    else if (ins[31:24] == 8'b10110100)     k = KIND_CBZ;
    else if (ins[31:24] == 8'b10110101)     k = KIND_CBNZ;
    else if (ins[31:24] == 8'b01010100)     k = KIND_BCOND;
    else if (ins[31:21] == 11'b11010110000) k = KIND_BR;
    else                                    k = KIND_NONE;
    return k;
  endfunction

  // Flags are packed {V, C, N, Z}; codes 14 and 15 both mean "always".
  function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cy, v, r;
    {v, cy, n, z} = f;
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cy;
      4'h3:    r = !cy;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cy && !z;
      4'h9:    r = !(cy && !z);
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = !(!z && (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  state_t            r_state;
  kind_t             r_kind;
  logic [4:0]        r_rt;
  logic [4:0]        r_rn;
  logic [3:0]        r_status;
  logic [DATA_W-1:0] r_k;
  logic              r_taken;
  logic              r_illegal;

  state_t            w_next_state;
  kind_t             w_dec_kind;
  logic [DATA_W-1:0] w_dec_k;
  logic              w_cond;
  logic              w_taken_now;
  logic [4:0]        w_alu_fs;
  logic              w_rf_b_en;
  logic [4:0]        w_rf_sa;
  logic [4:0]        w_rf_sb;
  logic [4:0]        w_rf_da;
  logic              w_rf_w;
  logic              w_pc_en;
  logic [1:0]        w_pc_fs;
  logic              w_unused;

  assign w_dec_kind  = decode_kind(I);
  assign w_cond      = cond_met(r_rt[3:0], r_status);
  assign w_taken_now = (r_kind == KIND_BCOND) ? w_cond : r_taken;
  assign w_unused    = status[4];

  // Sign-extended branch constant for the instruction being offered.
  always_comb begin
    case (w_dec_kind)
      KIND_B, KIND_BL:                 w_dec_k = {{(DATA_W-26){I[25]}}, I[25:0]};
      KIND_CBZ, KIND_CBNZ, KIND_BCOND: w_dec_k = {{(DATA_W-19){I[23]}}, I[23:5]};
      default:                         w_dec_k = {DATA_W{1'b0}};
    endcase
  end

  // State register and latched instruction fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_kind    <= KIND_NONE;
      r_rt      <= 5'd0;
      r_rn      <= 5'd0;
      r_status  <= 4'd0;
      r_k       <= {DATA_W{1'b0}};
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_rt     <= I[4:0];
            r_rn     <= I[9:5];
            r_status <= status[3:0];
            r_kind   <= w_dec_kind;
            if (w_dec_kind == KIND_NONE) begin
              r_illegal <= 1'b1;
            end else begin
              r_k     <= w_dec_k;
              r_taken <= (w_dec_kind == KIND_B) || (w_dec_kind == KIND_BR);
            end
          end
        end
        LINK:    r_taken <= 1'b1;
        // alu_zero reflects OR(XZR, Rt) during TEST, i.e. Rt == 0.
        TEST:    r_taken <= (r_kind == KIND_CBZ) ? alu_zero : !alu_zero;
        JUMP:    r_taken <= r_taken;
        default: r_taken <= 1'b0;
      endcase
    end
  end

  // Next state and control-word fields; defaults form the NOP word.
  always_comb begin
    w_alu_fs     = 5'b11111;
    w_rf_b_en    = 1'b0;
    w_rf_sa      = ZERO_A;
    w_rf_sb      = ZERO_A;
    w_rf_da      = ZERO_A;
    w_rf_w       = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_fs      = 2'b00;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (instr_valid) begin
          case (w_dec_kind)
            KIND_BL:             w_next_state = LINK;
            KIND_CBZ, KIND_CBNZ: w_next_state = TEST;
            KIND_NONE:           w_next_state = IDLE;
            default:             w_next_state = JUMP;
          endcase
        end else begin
          w_next_state = IDLE;
        end
      end
      LINK: begin
        w_pc_en      = 1'b1;
        w_rf_da      = LINK_A;
        w_rf_w       = 1'b1;
        w_next_state = JUMP;
      end
      TEST: begin
        w_alu_fs     = 5'b00100;
        w_rf_sb      = r_rt;
        w_next_state = JUMP;
      end
      JUMP: begin
        w_pc_en      = 1'b1;
        w_next_state = IDLE;
        if (r_kind == KIND_BR) begin
          w_rf_b_en = 1'b1;
          w_rf_sb   = r_rn;
          w_pc_fs   = 2'b11;
        end else if (w_taken_now) begin
          w_pc_fs = 2'b10;
        end else begin
          w_pc_fs = 2'b01;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // alu_en, alu_bs, ram_en, ram_w, pc_is and status_ld are never used by branches.
  assign cw = {1'b0, 1'b0, w_alu_fs, w_rf_b_en, w_rf_sa, w_rf_sb, w_rf_da, w_rf_w,
               1'b0, 1'b0, w_pc_en, w_pc_fs, 1'b0, 1'b0, w_next_state};

  assign K       = r_k;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == JUMP);
  assign taken   = (r_state == JUMP) && w_taken_now;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed plan cases plus randomized
// branches checked against a decode/condition model of the LEGv8 branch family.
module tb_branch_sequencer;

  localparam int K_ILL = 0, K_B = 1, K_BL = 2, K_CBZ = 3, K_CBNZ = 4, K_BCOND = 5, K_BR = 6;
  localparam logic [32:0] NOP_CW = {1'b0, 1'b0, 5'h1F, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0,
                                    1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] I = 32'd0;
  logic        instr_valid = 1'b0;
  logic [4:0]  status = 5'd0;
  logic        alu_zero = 1'b0;
  logic [32:0] cw;
  logic [63:0] K;
  logic        busy, done, taken, illegal;

  int          total = 0;
  int          bad = 0;
  logic [63:0] k_model = 64'd0;

  branch_sequencer dut (
    .clock(clock), .reset(reset), .I(I), .instr_valid(instr_valid), .status(status),
    .alu_zero(alu_zero), .cw(cw), .K(K), .busy(busy), .done(done), .taken(taken),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_kind(input logic [31:0] ins);
    if (ins[31:26] == 6'b000101) return K_B;
    if (ins[31:26] == 6'b100101) return K_BL;
    if (ins[31:24] == 8'hB4) return K_CBZ;
    if (ins[31:24] == 8'hB5) return K_CBNZ;
    if (ins[31:24] == 8'h54) return K_BCOND;
    if (ins[31:21] == 11'b11010110000) return K_BR;
    return K_ILL;
  endfunction

  function automatic logic [63:0] model_k(input logic [31:0] ins);
    longint v;
    int kd;
    kd = model_kind(ins);
    if (kd == K_B || kd == K_BL) begin
      v = longint'(ins[25:0]);
      if (v >= 64'sd33554432) v = v - 64'sd67108864;
    end else if (kd == K_CBZ || kd == K_CBNZ || kd == K_BCOND) begin
      v = longint'(ins[23:5]);
      if (v >= 64'sd262144) v = v - 64'sd524288;
    end else begin
      v = 64'sd0;
    end
    return 64'(v);
  endfunction

  // Base condition from c[3:1]; odd codes invert it, except NV which is "always".
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cf, v, r;
    {v, cf, n, z} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && c != 4'hF) r = !r;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] ins, input logic [4:0] st,
                         input logic az);
    int kind;
    logic [63:0] ek;
    logic et;
    logic [32:0] e, m;
    kind = model_kind(ins);
    I = ins; status = st; alu_zero = az; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; I = $urandom; status = 5'($urandom);
    if (kind == K_ILL) begin
      total++;
      if (illegal !== 1'b1 || busy !== 1'b0 || K !== k_model || cw !== NOP_CW) begin
        bad++;
        $display("FAIL %s_illegal: illegal=%b busy=%b K=%h cw=%h, want 1 0 %h %h",
                 tag, illegal, busy, K, cw, k_model, NOP_CW);
      end
      step();
      total++;
      if (illegal !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s_illegal_pulse: illegal=%b busy=%b, want 0 0", tag, illegal, busy);
      end
      return;
    end
    ek = model_k(ins);
    case (kind)
      K_CBZ:   et = az;
      K_CBNZ:  et = !az;
      K_BCOND: et = cond_holds(ins[3:0], st[3:0]);
      default: et = 1'b1;
    endcase
    if (kind == K_BL) begin
      e = NOP_CW; e[6] = 1'b1; e[14:10] = 5'd30; e[9] = 1'b1; e[1:0] = 2'd3;
      total++;
      if (cw !== e || busy !== 1'b1 || done !== 1'b0 || K !== ek) begin
        bad++;
        $display("FAIL %s_link: cw=%h busy=%b done=%b K=%h, want %h 1 0 %h",
                 tag, cw, busy, done, K, e, ek);
      end
      step();
    end else if (kind == K_CBZ || kind == K_CBNZ) begin
      m = '0; m[32] = 1'b1; m[31] = 1'b1; m[30:26] = '1; m[24:20] = '1; m[19:15] = '1;
      m[7] = 1'b1; m[2] = 1'b1; m[1:0] = '1;
      e = '0; e[30:26] = 5'b00100; e[24:20] = 5'd31; e[19:15] = ins[4:0]; e[1:0] = 2'd3;
      total++;
      if ((cw & m) !== e || busy !== 1'b1 || done !== 1'b0 || K !== ek) begin
        bad++;
        $display("FAIL %s_test: cw&m=%h busy=%b done=%b K=%h, want %h 1 0 %h",
                 tag, cw & m, busy, done, K, e, ek);
      end
      step();
    end
    m = '0; m[5:4] = 2'b11; m[7] = 1'b1; m[2] = 1'b1; m[1:0] = 2'b11;
    e = '0;
    if (kind == K_BR) begin
      m[25] = 1'b1; m[19:15] = '1;
      e[25] = 1'b1; e[19:15] = ins[9:5]; e[5:4] = 2'b11;
    end else begin
      e[5:4] = et ? 2'b10 : 2'b01;
    end
    total++;
    if ((cw & m) !== e || done !== 1'b1 || taken !== et || busy !== 1'b1 || K !== ek) begin
      bad++;
      $display("FAIL %s_jump: cw&m=%h done=%b taken=%b busy=%b K=%h, want %h 1 %b 1 %h",
               tag, cw & m, done, taken, busy, K, e, et, ek);
    end
    k_model = ek;
    step();
    total++;
    if (cw !== NOP_CW || busy !== 1'b0 || done !== 1'b0 || K !== ek) begin
      bad++;
      $display("FAIL %s_after: cw=%h busy=%b done=%b K=%h, want %h 0 0 %h",
               tag, cw, busy, done, K, NOP_CW, ek);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++;
    if (cw !== NOP_CW || K !== 64'd0 || busy !== 1'b0 || done !== 1'b0 ||
        taken !== 1'b0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset: cw=%h K=%h busy=%b done=%b taken=%b illegal=%b, want NOP 0 0 0 0 0",
               cw, K, busy, done, taken, illegal);
    end
    @(negedge clock);
    reset = 1'b0;
    step();
    total++;
    if (cw !== NOP_CW || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: cw=%h busy=%b, want %h 0", cw, busy, NOP_CW);
    end
  endtask

  task automatic test_b();
    run_one("b", 32'h1400_0010, 5'd0, 1'b0);
    total++;
    if (K !== 64'h10) begin
      bad++;
      $display("FAIL b_k: K=%h, want 10", K);
    end
  endtask

  task automatic test_bl();
    run_one("bl", 32'h97FF_FFFF, 5'd0, 1'b0);
    total++;
    if (K !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL bl_k: K=%h, want all ones", K);
    end
  endtask

  task automatic test_cb();
    run_one("cbz_nz", 32'hB400_0043, 5'd0, 1'b0);
    run_one("cbz_z", 32'hB400_0043, 5'd0, 1'b1);
    run_one("cbnz_nz", 32'hB500_0043, 5'd0, 1'b0);
    run_one("cbnz_z", 32'hB500_0043, 5'd0, 1'b1);
  endtask

  task automatic test_bcond();
    run_one("bc_gt", 32'h5400_004C, 5'b01010, 1'b0);
    run_one("bc_le", 32'h5400_004D, 5'b01010, 1'b0);
    run_one("bc_al", 32'h5400_004E, 5'b01010, 1'b0);
    for (int c = 0; c < 16; c++) begin
      logic [31:0] w;
      w = {8'h54, 19'($urandom), 1'b0, 4'(c)};
      run_one("bc_sweep", w, 5'($urandom), 1'b0);
    end
  endtask

  task automatic test_br();
    run_one("br", 32'hD61F_00E0, 5'd0, 1'b0);
    total++;
    if (K !== 64'd0) begin
      bad++;
      $display("FAIL br_k: K=%h, want 0", K);
    end
  endtask

  task automatic test_illegal();
    run_one("bl_pre", 32'h9400_0123, 5'd0, 1'b0);
    run_one("ill", 32'h8B00_0000, 5'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    I = 32'h97FF_FFFF; status = 5'd0; instr_valid = 1'b1;
    step();
    I = 32'h1400_0010;
    total++;
    if (busy !== 1'b1 || cw[14:10] !== 5'd30 || cw[9] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_link: busy=%b rf_da=%0d rf_w=%b, want 1 30 1", busy, cw[14:10], cw[9]);
    end
    step();
    total++;
    if (done !== 1'b1 || K !== 64'hFFFF_FFFF_FFFF_FFFF || cw[5:4] !== 2'b10) begin
      bad++;
      $display("FAIL b2b_jump: done=%b K=%h pc_fs=%b, want 1 all-ones 10", done, K, cw[5:4]);
    end
    step();
    total++;
    if (busy !== 1'b0 || cw[1:0] !== 2'd3) begin
      bad++;
      $display("FAIL b2b_idle: busy=%b next_state=%0d, want 0 3", busy, cw[1:0]);
    end
    step();
    instr_valid = 1'b0;
    total++;
    if (done !== 1'b1 || taken !== 1'b1 || K !== 64'h10) begin
      bad++;
      $display("FAIL b2b_second: done=%b taken=%b K=%h, want 1 1 10", done, taken, K);
    end
    step();
    k_model = 64'h10;
  endtask

  task automatic test_reset_mid();
    I = 32'h97FF_FFFF; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || cw[9] !== 1'b1) begin
      bad++;
      $display("FAIL rmid_link: busy=%b rf_w=%b, want 1 1", busy, cw[9]);
    end
    reset = 1'b1;
    #1;
    total++;
    if (cw !== NOP_CW || busy !== 1'b0 || done !== 1'b0 || K !== 64'd0) begin
      bad++;
      $display("FAIL rmid_async: cw=%h busy=%b done=%b K=%h, want %h 0 0 0",
               cw, busy, done, K, NOP_CW);
    end
    @(negedge clock);
    reset = 1'b0;
    step();
    total++;
    if (cw !== NOP_CW || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after: cw=%h busy=%b, want %h 0", cw, busy, NOP_CW);
    end
    k_model = 64'd0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] r, w;
      r = $urandom;
      case ($urandom_range(0, 6))
        0: begin
          w = r;
          while (model_kind(w) != K_ILL) w = $urandom;
        end
        1:       w = {6'b000101, r[25:0]};
        2:       w = {6'b100101, r[25:0]};
        3:       w = {8'hB4, r[23:0]};
        4:       w = {8'hB5, r[23:0]};
        5:       w = {8'h54, r[23:0]};
        default: w = {11'b11010110000, r[20:0]};
      endcase
      run_one("rand", w, 5'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_b();
    test_bl();
    test_cb();
    test_bcond();
    test_br();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Multi-cycle branch sequencer for the control unit. Covers the full LEGv8 branch family: B, BL, CBZ, CBNZ, B.cond and BR. It replaces the per-opcode single-cycle branch decoders.
- Accepts one instruction word, latches it, and steps a small FSM.
- Emits the standard 33-bit control word each cycle, plus the branch constant K.
- Sits beside the other instruction decoders and feeds the control-word mux.

Parameters:
DATA_W, 64, width of K and the datapath
LINK_REG, 30, register written by BL
ZERO_REG, 31, register index used as XZR / don't-care address

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
I  input  32  instruction word
instr_valid  input  1  I is a branch-class instruction to execute
status  input  5  flags: [0]Z [1]N [2]C [3]V [4] unused
alu_zero  input  1  unregistered ALU zero output
cw  output  33  control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa, rf_sb, rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}
K  output  DATA_W  sign-extended branch constant
busy  output  1  FSM not in IDLE
done  output  1  PC update commits at the end of this cycle
taken  output  1  valid with done; branch redirects the PC
illegal  output  1  one-cycle pulse: accepted opcode is not a branch

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; latched instruction = 0; K = 0.
  - busy = done = taken = illegal = 0.
- cw is combinational from the registered state and latched fields.
- pc_fs encoding: 00 hold, 01 PC+4, 10 PC+(K<<2), 11 load from databus.
- NOP control word, driven in IDLE and at reset:
  - all fields 0, except alu_fs = 5'b11111 and rf_sa = rf_sb = rf_da = ZERO_REG.
  - next_state mirrors the FSM next state.
- States: IDLE=2'd0, LINK=2'd1, TEST=2'd2, JUMP=2'd3.
- Accept:
  - Occurs in IDLE when instr_valid=1.
  - Latches I and status. instr_valid while busy is ignored.
- Decode at accept:
  - B: opcode[31:26]=000101. K = sext(I[25:0]). Next state JUMP; taken=1.
  - BL: opcode[31:26]=100101. K = sext(I[25:0]). Next state LINK.
  - CBZ / CBNZ: I[31:24] = 10110100 / 10110101. K = sext(I[23:5]). Next state TEST.
  - B.cond: I[31:24]=01010100. K = sext(I[23:5]). Condition I[3:0] is evaluated on the latched status. Next state JUMP.
  - B.cond condition codes:
    - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V
    - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !GT; AL/NV 1
  - BR: I[31:21]=11010110000. K = 0. Next state JUMP; taken=1.
  - Other opcodes: illegal=1 for one cycle; state stays IDLE; K unchanged.
- LINK (BL only):
  - cw: pc_en=1, rf_da=LINK_REG, rf_w=1, pc_fs=00, other fields NOP.
  - Next state JUMP; taken=1.
- TEST (CBZ/CBNZ):
  - cw: alu_bs=0, alu_fs=5'b00100 (OR), rf_sa=ZERO_REG, rf_sb=I[4:0], alu_en=0, status_ld=0.
  - At the clock edge, taken = alu_zero for CBZ, !alu_zero for CBNZ.
  - Next state JUMP.
- JUMP:
  - cw: pc_fs = 10 if taken, else 01.
  - For BR: rf_b_en=1, rf_sb=I[9:5], pc_fs=11.
  - done=1. Next state IDLE.
  - A new instruction may be accepted in the following cycle.
- Latency, accept to done:
  - B, BR, B.cond: 1 cycle.
  - BL, CBZ, CBNZ: 2 cycles.
- status_ld=0 and ram_w=0 in every state; branches never alter flags or memory.
- K is held stable from accept until the next successful accept.
- Reset mid-sequence: returns immediately to IDLE and NOP. No partial link write occurs after reset deasserts.

Test Plan:
- B: I=0x14000010 accepted -> next cycle JUMP, K=0x10, pc_fs=10, done=1, taken=1; busy low after.
- BL negative offset: I=0x97FFFFFF -> LINK cycle (rf_da=30, rf_w=1, pc_en=1), then JUMP with K=64'hFFFF_FFFF_FFFF_FFFF, pc_fs=10.
- CBZ: X3 with alu_zero=0 in TEST -> taken=0, pc_fs=01. Repeat with alu_zero=1 -> taken=1, pc_fs=10. CBNZ gives the inverse.
- B.cond: cond GT with status N=1 V=1 Z=0 -> taken=1; cond LE with the same flags -> taken=0; AL -> taken=1.
- BR X7: I=0xD61F00E0 -> JUMP with rf_b_en=1, rf_sb=7, pc_fs=11, K=0.
- Protocol: instr_valid held high during BL (ignored until IDLE); illegal opcode 0x8B000000 pulses illegal with busy=0; reset asserted during LINK -> cw=NOP and state IDLE.
